// File: rtl/ddr_word_tx.sv
// rtl/ddr_word_tx.sv - MSB-first word serializer driving two bits per clock on a dual-edge line.
// Optional even-parity trailer cycle when DDR_TX_PARITY_EN is defined.
module ddr_word_tx #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              frame,
  output logic              busy
);

  localparam int NPAIR = WORD_W / 2;
  localparam int CNT_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAIR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef DDR_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;
  logic              frame_q, frame_d;
  logic              last_cycle;
  logic              accept;
`ifdef DDR_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    last_cycle = 1'b0;
`ifdef DDR_TX_PARITY_EN
    last_cycle = (state_q == ST_PAR);
`else
    last_cycle = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
`endif
  end

  // in_ready is held low for the whole time rst is asserted, not just after the edge.
  assign in_ready = !rst && ((state_q == ST_IDLE) || last_cycle);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    frame_d = 1'b0;
`ifdef DDR_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        hi_d    = sr_q[WORD_W-1];
        lo_d    = sr_q[WORD_W-2];
        frame_d = 1'b1;
        sr_d    = {sr_q[WORD_W-3:0], 2'b00};
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef DDR_TX_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef DDR_TX_PARITY_EN
      ST_PAR: begin
        hi_d    = par_q;
        lo_d    = ~par_q;
        frame_d = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A word taken in the last frame cycle overrides the return to idle.
    if (accept) begin
      sr_d    = in_data;
      cnt_d   = '0;
      state_d = ST_SHIFT;
`ifdef DDR_TX_PARITY_EN
      par_d   = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      frame_q <= 1'b0;
`ifdef DDR_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      frame_q <= frame_d;
`ifdef DDR_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Both mux inputs are flops, so the only transitions on dout follow clk edges.
  assign dout  = clk ? hi_q : lo_q;
  assign frame = frame_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_word_tx.sv
// tb/tb_ddr_word_tx.sv - randomized self-checking bench for ddr_word_tx against a bit-pair queue model.
module tb_ddr_word_tx;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         dout;
  logic         frame;
  logic         busy;

  int n_total;
  int n_bad;

  // Pairs {hi,lo} still owed on the line, oldest first.
  logic [1:0] q[$];

  ddr_word_tx #(.WORD_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .frame    (frame),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic [1:0] pr;
    for (int i = 0; i < W / 2; i++) begin
      pr = {w[W-1-2*i], w[W-2-2*i]};
      q.push_back(pr);
    end
`ifdef DDR_TX_PARITY_EN
    pr = {^w, ~(^w)};
    q.push_back(pr);
`endif
  endtask

  // One clock: drive, let the model advance at the posedge, check both phases.
  task automatic step(input logic v, input logic [W-1:0] d);
    logic       acc;
    logic [1:0] exp_pr;
    logic       exp_frame;
    in_valid = v;
    in_data  = d;
    acc = v && (q.size() <= 1);
    @(posedge clk);
    if (q.size() > 0) begin
      exp_pr    = q.pop_front();
      exp_frame = 1'b1;
    end else begin
      exp_pr    = 2'b00;
      exp_frame = 1'b0;
    end
    if (acc) push_word(d);
    #1;
    check_eq("frame", {31'd0, frame}, {31'd0, exp_frame});
    check_eq("busy", {31'd0, busy}, {31'd0, q.size() > 0});
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, q.size() <= 1});
    check_eq("dout_hi", {31'd0, dout}, {31'd0, exp_pr[1]});
    @(negedge clk);
    #1;
    check_eq("dout_lo", {31'd0, dout}, {31'd0, exp_pr[0]});
  endtask

  task automatic send(input logic [W-1:0] w);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      got = in_ready;
      step(1'b1, w);
    end
    check_eq("send_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
  endtask

  // Assert rst in the low phase, away from any posedge, and release a cycle later.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_dout", {31'd0, dout}, 32'd0);
    check_eq("rst_frame", {31'd0, frame}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_dout_hi", {31'd0, dout}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    check_eq("rel_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rel_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check_eq("init_frame", {31'd0, frame}, 32'd0);
    check_eq("init_busy", {31'd0, busy}, 32'd0);
    check_eq("init_dout", {31'd0, dout}, 32'd0);
    check_eq("init_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_dout_hi", {31'd0, dout}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);

    send(16'hA5C3);
    idle(12);

    send(16'hFFFF);
    send(16'h0000);
    idle(12);

    send(16'hA5C3);
    idle(2);
    send(16'h1234);
    idle(12);

    send(16'hA5C3);
    idle(3);
    pulse_reset();
    idle(12);

    idle(20);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step($urandom_range(0, 3) != 0, W'($urandom));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_word_tx.md
DDR_WORD_TX -- requirements
Module: ddr_word_tx

Interface
REQ-001 Parameter: WORD_W, default 16, serialized word width; SHALL be even and at least 4.
REQ-002 Port: clk  input  1  single system clock; posedge registers all state; its level also selects the output half-bit.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_data  input  WORD_W  word to transmit, MSB first.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  block accepts a word on this posedge when in_valid is high.
REQ-007 Port: dout  output  1  dual-edge data line: carries hi_bit while clk=1 and lo_bit while clk=0.
REQ-008 Port: frame  output  1  registered; high for every cycle that carries frame bits.
REQ-009 Port: busy  output  1  high when state is not IDLE.

Function
REQ-010 States SHALL be IDLE, SHIFT and PAR; PAR exists only with PARITY_EN.
REQ-011 Transfer SHALL occur on a posedge where in_valid=1 and in_ready=1; in_data SHALL be loaded into the shift register and the state SHALL go to SHIFT.
REQ-012 The first bit pair SHALL appear starting at the posedge after acceptance; latency is 1 cycle.
REQ-013 Each SHIFT cycle SHALL register hi_bit=sr[MSB] and lo_bit=sr[MSB-1], then shift sr left by 2.
REQ-014 dout SHALL be hi_bit during the high phase after a posedge and lo_bit during the following low phase, as a glitch-free clock-level mux of two registers.
REQ-015 SHIFT SHALL last exactly WORD_W/2 cycles, counted by a log2(WORD_W/2)-bit counter that wraps to 0 at frame end.
REQ-016 frame SHALL be 1 for every SHIFT and PAR cycle and 0 in IDLE; in IDLE, hi_bit=lo_bit=0.
REQ-017 in_ready SHALL be 1 in IDLE and in the last cycle of the frame (last SHIFT cycle without parity, PAR cycle with parity); otherwise 0.
REQ-018 A word accepted in the last cycle SHALL start the next cycle, so frame stays continuously high with no gap cycle.
REQ-019 With no word accepted in the last cycle, the state SHALL return to IDLE.
REQ-020 in_valid while in_ready=0 SHALL be ignored; in_data SHALL NOT be sampled.
REQ-021 When frame is low, dout SHALL be 0 in both clock phases.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, sr=0, hi_bit=lo_bit=0, frame=0, busy=0, dout=0.
REQ-023 in_ready SHALL be 0 while rst=1 and SHALL rise with the state at IDLE after rst deasserts.
REQ-024 Reset during a frame SHALL discard the word; no partial bits or parity SHALL follow the release.

Configuration
REQ-025 Macro DDR_TX_PARITY_EN defined: after SHIFT, one PAR cycle with hi_bit=XOR of all word bits (even parity) and lo_bit=its inverse; frame length is WORD_W/2+1 cycles.
REQ-026 DDR_TX_PARITY_EN undefined: PAR state and parity logic are absent; frame length is WORD_W/2 cycles.

Verification
REQ-027 Single word 16'hA5C3 from IDLE: accepted; the next 8 cycles show (hi,lo) = 10,10,01,01,11,00,00,11 with frame=1; then frame=0 and dout=0.
REQ-028 With parity on, word 16'hA5C3: a ninth frame cycle with (hi,lo)=01; in_ready=1 only in that cycle.
REQ-029 Back-to-back 16'hFFFF then 16'h0000 with in_valid held: frame high for 16 consecutive cycles; dout=1 both phases for 8 cycles, then 0.
REQ-030 in_valid=1 with 16'h1234 during SHIFT cycle 3 of 16'hA5C3: ignored; A5C3 bits are unchanged; 1234 starts only after an accept in the last cycle.
REQ-031 rst pulsed between posedges during SHIFT cycle 4: dout, frame and busy go to 0 at once; after release, in_ready=1 and no residual bits appear.
REQ-032 Idle line with in_valid=0 for 20 cycles: frame=0, busy=0, dout=0 in both phases.
